status_vector_fifo: RTL and testbench
=====================================

Name: status_vector_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO that carries the packed 10G status word {pcs_pma_status_vector, mac_status_vector, pcspma_status}.
- An output stage splits the popped word into three held status registers.
- Sits between the 10G MAC/PCS-PMA status outputs and the register/host side of the 10G interface wrapper.

Parameters:
- DATA_WIDTH, 458, width of one status word; must be ≥ 11.
- DEPTH, 16, number of FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- core_clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  status word to push; bits [7:0] pcspma_status, [9:8] mac_status_vector, [DATA_WIDTH-1:10] pcs_pma_status_vector.
- wr_en  input  1  push request.
- rd_en  input  1  pop request.
- dout  output  DATA_WIDTH  head-of-FIFO word (FWFT).
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- data_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- pcspma_status  output  8  held copy of last popped dout[7:0].
- mac_status_vector  output  2  held copy of last popped dout[9:8].
- pcs_pma_status_vector  output  DATA_WIDTH-10  held copy of last popped dout[DATA_WIDTH-1:10].

Behaviour:
- Reset (reset=1 at a core_clk edge):
  - read/write pointers and data_count go to 0; empty=1, full=0.
  - pcspma_status, mac_status_vector and pcs_pma_status_vector go to 0.
  - Memory contents are not cleared.
  - Reset applied mid-operation discards all stored words; the next cycle sees an empty FIFO.
- Push accepted when wr_en=1 and full=0: din is written at the write pointer, and the pointer increments modulo DEPTH.
  - wr_en=1 while full=1 is ignored: no overwrite, no pointer change, no error flag.
  - full gates the write even if rd_en=1 in the same cycle.
- Pop accepted when rd_en=1 and empty=0: the read pointer increments modulo DEPTH.
  - rd_en=1 while empty=1 is ignored.
- Simultaneous accepted push and pop: occupancy is unchanged; both pointers advance.
- Pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty on wrap-around.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
  - Both flags are registered and update on the edge following the causing event.
- FWFT output:
  - dout is the word at the read pointer whenever empty=0; dout=0 whenever empty=1.
  - A word pushed into an empty FIFO at edge N appears on dout, with empty=0, after edge N.
  - After a pop, the next word is presented on dout in the following cycle with no extra latency.
- Held status outputs:
  - On each accepted pop, at the same edge, the current dout is split into the three registers: [7:0] to pcspma_status, [9:8] to mac_status_vector, [DATA_WIDTH-1:10] to pcs_pma_status_vector.
  - With no accepted pop, the registers hold their values.
- Streaming use: wr_en tied to ~full and rd_en tied to ~empty continuously samples status; held outputs trail din by 2 cycles.
- data_count:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.

Test Plan:
- Reset: hold reset 2 cycles -> empty=1, full=0, data_count=0, dout=0, all held status outputs 0.
- Single word: push din with [7:0]=0xA5, [9:8]=2'b10, upper=all-ones -> next cycle empty=0, dout=din; pop -> next cycle pcspma_status=0xA5, mac_status_vector=2'b10, pcs_pma_status_vector all-ones, empty=1, dout=0.
- Fill/overflow: push 1..16 -> full=1, data_count=16; push 17 while full -> ignored; pop all -> order 1..16, value 17 never appears.
- Underflow: rd_en=1 on empty for 3 cycles -> pointers, data_count and held outputs unchanged.
- Simultaneous push and pop:
  - At occupancy 5: data_count stays 5, order preserved.
  - At full with wr_en=rd_en=1: pop occurs, write dropped, data_count=15.
- Wrap and reset: stream 40 words with wr_en=~full, rd_en=~empty -> all 40 popped in order across pointer wrap. Then assert reset with 3 words stored -> empty=1, held outputs 0.

Source files
------------

// File: rtl/status_vector_fifo_if.sv
// Handshake and status bundle between a status-word producer/consumer and status_vector_fifo.
// The FIFO side takes the slave modport; the host/bench side takes the master modport.
interface status_vector_fifo_if #(
  parameter int DATA_WIDTH = 458,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0]  din;
  logic                   wr_en;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       data_count;
  logic [7:0]             pcspma_status;
  logic [1:0]             mac_status_vector;
  logic [DATA_WIDTH-11:0] pcs_pma_status_vector;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, data_count,
    input  pcspma_status, mac_status_vector, pcs_pma_status_vector
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, data_count,
    output pcspma_status, mac_status_vector, pcs_pma_status_vector
  );
endinterface

// File: rtl/status_vector_fifo.sv
// First-word-fall-through FIFO for the packed 10G status word, with an output stage that
// splits each popped word into held pcspma / mac / pcs_pma status registers.
module status_vector_fifo #(
  parameter int DATA_WIDTH = 458,
  parameter int DEPTH      = 16
) (
  input  logic               core_clk,
  input  logic               reset,
  status_vector_fifo_if.slave fifo_if
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   push, pop;
  logic [DATA_WIDTH-1:0]  head;
  logic [7:0]             pcspma_q, pcspma_d;
  logic [1:0]             mac_q, mac_d;
  logic [DATA_WIDTH-11:0] pcs_pma_q, pcs_pma_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    push      = fifo_if.wr_en & ~full_q;
    pop       = fifo_if.rd_en & ~empty_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    // The extra pointer MSB lets a plain subtraction tell a full FIFO from an empty one.
    count_d   = wr_ptr_d - rd_ptr_d;
    full_d    = (count_d == PTR_W'(DEPTH));
    empty_d   = (count_d == '0);
    head      = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    pcspma_d  = pcspma_q;
    mac_d     = mac_q;
    pcs_pma_d = pcs_pma_q;
    if (pop) begin
      pcspma_d  = head[7:0];
      mac_d     = head[9:8];
      pcs_pma_d = head[DATA_WIDTH-1:10];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge core_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      pcspma_q  <= '0;
      mac_q     <= '0;
      pcs_pma_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      pcspma_q  <= pcspma_d;
      mac_q     <= mac_d;
      pcs_pma_q <= pcs_pma_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge core_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= fifo_if.din;
    end
  end

  assign fifo_if.dout                  = head;
  assign fifo_if.full                  = full_q;
  assign fifo_if.empty                 = empty_q;
  assign fifo_if.data_count            = count_q;
  assign fifo_if.pcspma_status         = pcspma_q;
  assign fifo_if.mac_status_vector     = mac_q;
  assign fifo_if.pcs_pma_status_vector = pcs_pma_q;
endmodule

// File: tb/tb_status_vector_fifo.sv
// Randomized self-checking bench for status_vector_fifo against a queue-based reference model.
module tb_status_vector_fifo;
  localparam int DW = 458;
  localparam int DP = 16;
  localparam int CW = $clog2(DP) + 1;

  logic core_clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  status_vector_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) fifo_if ();

  status_vector_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .core_clk (core_clk),
    .reset    (reset),
    .fifo_if  (fifo_if)
  );

  always #5 core_clk = ~core_clk;

  // Reference model: queue of stored words plus the last popped word.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_held;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    repeat ((DW + 31) / 32) w = (w << 32) | DW'($urandom);
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_dout();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic logic [DW-1:0] dut_held();
    return {fifo_if.pcs_pma_status_vector, fifo_if.mac_status_vector, fifo_if.pcspma_status};
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic rst);
    bit m_full, m_empty;
    fifo_if.wr_en = w;
    fifo_if.rd_en = r;
    fifo_if.din   = d;
    reset         = rst;
    @(posedge core_clk);
    m_full  = (mq.size() == DP);
    m_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_held = '0;
    end else begin
      if (r && !m_empty) m_held = mq.pop_front();
      if (w && !m_full) mq.push_back(d);
    end
    @(negedge core_clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    tests_run++; if (fifo_if.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", fifo_if.empty); end
    tests_run++; if (fifo_if.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", fifo_if.full); end
    tests_run++; if (fifo_if.data_count !== CW'(0)) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", fifo_if.data_count); end
    tests_run++; if (fifo_if.dout !== '0) begin tests_failed++; $display("FAIL reset_dout got %h exp 0", fifo_if.dout); end
    tests_run++; if (dut_held() !== '0) begin tests_failed++; $display("FAIL reset_held got %h exp 0", dut_held()); end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] d;
    d = {{(DW-10){1'b1}}, 2'b10, 8'hA5};
    drive(1'b1, 1'b0, d, 1'b0);
    tests_run++; if (fifo_if.empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty_after_push got %b exp 0", fifo_if.empty); end
    tests_run++; if (fifo_if.dout !== d) begin tests_failed++; $display("FAIL single_dout got %h exp %h", fifo_if.dout, d); end
    drive(1'b0, 1'b1, '0, 1'b0);
    tests_run++; if (fifo_if.pcspma_status !== 8'hA5) begin tests_failed++; $display("FAIL single_pcspma got %h exp a5", fifo_if.pcspma_status); end
    tests_run++; if (fifo_if.mac_status_vector !== 2'b10) begin tests_failed++; $display("FAIL single_mac got %b exp 10", fifo_if.mac_status_vector); end
    tests_run++; if (fifo_if.pcs_pma_status_vector !== {(DW-10){1'b1}}) begin tests_failed++; $display("FAIL single_pcs_pma got %h exp all ones", fifo_if.pcs_pma_status_vector); end
    tests_run++; if (fifo_if.empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty_after_pop got %b exp 1", fifo_if.empty); end
    tests_run++; if (fifo_if.dout !== '0) begin tests_failed++; $display("FAIL single_dout_empty got %h exp 0", fifo_if.dout); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DP; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
    tests_run++; if (fifo_if.full !== 1'b1) begin tests_failed++; $display("FAIL fill_full got %b exp 1", fifo_if.full); end
    tests_run++; if (fifo_if.data_count !== CW'(DP)) begin tests_failed++; $display("FAIL fill_count got %0d exp %0d", fifo_if.data_count, DP); end
    drive(1'b1, 1'b0, DW'(17), 1'b0);
    tests_run++; if (fifo_if.data_count !== CW'(DP)) begin tests_failed++; $display("FAIL overflow_count got %0d exp %0d", fifo_if.data_count, DP); end
    tests_run++; if (fifo_if.dout !== DW'(1)) begin tests_failed++; $display("FAIL overflow_head got %h exp 1", fifo_if.dout); end
    for (int i = 1; i <= DP; i++) begin
      tests_run++; if (fifo_if.dout !== DW'(i)) begin tests_failed++; $display("FAIL drain_order[%0d] got %h exp %h", i, fifo_if.dout, DW'(i)); end
      drive(1'b0, 1'b1, '0, 1'b0);
    end
    tests_run++; if (fifo_if.empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %b exp 1", fifo_if.empty); end
    tests_run++; if (dut_held() !== DW'(DP)) begin tests_failed++; $display("FAIL drain_last_held got %h exp %h", dut_held(), DW'(DP)); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, rand_word(), 1'b0);
      tests_run++; if (fifo_if.data_count !== CW'(0)) begin tests_failed++; $display("FAIL underflow_count got %0d exp 0", fifo_if.data_count); end
      tests_run++; if (fifo_if.empty !== 1'b1) begin tests_failed++; $display("FAIL underflow_empty got %b exp 1", fifo_if.empty); end
      tests_run++; if (dut_held() !== m_held) begin tests_failed++; $display("FAIL underflow_held got %h exp %h", dut_held(), m_held); end
    end
    // Pointers must be intact: a following push/pop still works in order.
    drive(1'b1, 1'b0, DW'(99), 1'b0);
    tests_run++; if (fifo_if.dout !== DW'(99)) begin tests_failed++; $display("FAIL underflow_recover got %h exp 63", fifo_if.dout); end
    drive(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, rand_word(), 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, rand_word(), 1'b0);
      tests_run++; if (fifo_if.data_count !== CW'(5)) begin tests_failed++; $display("FAIL simul_count got %0d exp 5", fifo_if.data_count); end
      tests_run++; if (fifo_if.dout !== exp_dout()) begin tests_failed++; $display("FAIL simul_head got %h exp %h", fifo_if.dout, exp_dout()); end
      tests_run++; if (dut_held() !== m_held) begin tests_failed++; $display("FAIL simul_held got %h exp %h", dut_held(), m_held); end
    end
    while (mq.size() != 0) begin
      tests_run++; if (fifo_if.dout !== exp_dout()) begin tests_failed++; $display("FAIL simul_drain got %h exp %h", fifo_if.dout, exp_dout()); end
      drive(1'b0, 1'b1, '0, 1'b0);
    end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] x;
    logic [DW-1:0] first;
    bit            seen_x;
    first = rand_word();
    drive(1'b1, 1'b0, first, 1'b0);
    for (int i = 1; i < DP; i++) drive(1'b1, 1'b0, rand_word(), 1'b0);
    x = rand_word();
    drive(1'b1, 1'b1, x, 1'b0);
    tests_run++; if (fifo_if.data_count !== CW'(DP - 1)) begin tests_failed++; $display("FAIL full_simul_count got %0d exp %0d", fifo_if.data_count, DP - 1); end
    tests_run++; if (fifo_if.full !== 1'b0) begin tests_failed++; $display("FAIL full_simul_full got %b exp 0", fifo_if.full); end
    tests_run++; if (dut_held() !== first) begin tests_failed++; $display("FAIL full_simul_held got %h exp %h", dut_held(), first); end
    seen_x = 1'b0;
    while (mq.size() != 0) begin
      if (fifo_if.dout === x) seen_x = 1'b1;
      tests_run++; if (fifo_if.dout !== exp_dout()) begin tests_failed++; $display("FAIL full_simul_drain got %h exp %h", fifo_if.dout, exp_dout()); end
      drive(1'b0, 1'b1, '0, 1'b0);
    end
    tests_run++; if (seen_x) begin tests_failed++; $display("FAIL full_simul_dropped got seen=1 exp seen=0"); end
  endtask

  task automatic test_stream_wrap();
    int  pushed, popped, cyc;
    logic w, r;
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 200) begin
      w = !fifo_if.full && (pushed < 40);
      r = !fifo_if.empty;
      if (w && mq.size() != DP) pushed++;
      if (r && mq.size() != 0) popped++;
      drive(w, r, rand_word(), 1'b0);
      cyc++;
      tests_run++; if (fifo_if.dout !== exp_dout()) begin tests_failed++; $display("FAIL stream_dout got %h exp %h", fifo_if.dout, exp_dout()); end
      tests_run++; if (dut_held() !== m_held) begin tests_failed++; $display("FAIL stream_held got %h exp %h", dut_held(), m_held); end
    end
    tests_run++; if (popped != 40) begin tests_failed++; $display("FAIL stream_popped got %0d exp 40 (cycle budget)", popped); end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rand_word(), 1'b0);
    tests_run++; if (fifo_if.data_count !== CW'(3)) begin tests_failed++; $display("FAIL prereset_count got %0d exp 3", fifo_if.data_count); end
    drive(1'b0, 1'b0, '0, 1'b1);
    tests_run++; if (fifo_if.empty !== 1'b1) begin tests_failed++; $display("FAIL midreset_empty got %b exp 1", fifo_if.empty); end
    tests_run++; if (fifo_if.data_count !== CW'(0)) begin tests_failed++; $display("FAIL midreset_count got %0d exp 0", fifo_if.data_count); end
    tests_run++; if (dut_held() !== '0) begin tests_failed++; $display("FAIL midreset_held got %h exp 0", dut_held()); end
    tests_run++; if (fifo_if.dout !== '0) begin tests_failed++; $display("FAIL midreset_dout got %h exp 0", fifo_if.dout); end
  endtask

  task automatic test_random();
    logic w, r, rst;
    for (int i = 0; i < 400; i++) begin
      w   = ($urandom_range(0, 99) < 55);
      r   = ($urandom_range(0, 99) < 50);
      rst = ($urandom_range(0, 99) == 0);
      drive(w, r, rand_word(), rst);
      tests_run++; if (fifo_if.dout !== exp_dout()) begin tests_failed++; $display("FAIL rand_dout cyc %0d got %h exp %h", i, fifo_if.dout, exp_dout()); end
      tests_run++; if (fifo_if.data_count !== CW'(mq.size())) begin tests_failed++; $display("FAIL rand_count cyc %0d got %0d exp %0d", i, fifo_if.data_count, mq.size()); end
      tests_run++; if (fifo_if.full !== (mq.size() == DP)) begin tests_failed++; $display("FAIL rand_full cyc %0d got %b", i, fifo_if.full); end
      tests_run++; if (fifo_if.empty !== (mq.size() == 0)) begin tests_failed++; $display("FAIL rand_empty cyc %0d got %b", i, fifo_if.empty); end
      tests_run++; if (dut_held() !== m_held) begin tests_failed++; $display("FAIL rand_held cyc %0d got %h exp %h", i, dut_held(), m_held); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    fifo_if.din   = '0;
    m_held        = '0;
    @(negedge core_clk);
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_full_simul();
    test_stream_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
